// File: rtl/output_layer_mac.sv
// output_layer_mac: output-layer dot products over weight ROM and hidden RAM, then arg-max digit select
module output_layer_mac #(
    parameter int NUM_HIDDEN = 32,
    parameter int NUM_OUT    = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [DATA_WIDTH-1:0]        w_data,
    output logic [$clog2(NUM_HIDDEN)-1:0] hid_addr,
    input  logic [DATA_WIDTH-1:0]        hid_data,
    output logic                         busy,
    output logic                         done,
    output logic [3:0]                   digit,
    output logic signed [ACC_WIDTH-1:0]  max_acc
);
    localparam int HW = $clog2(NUM_HIDDEN);
    localparam int PW = 2*DATA_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, CMP, DONE} state_t;

    state_t                      state, state_nx;
    logic [3:0]                  out_idx;
    logic [HW-1:0]               hid_idx;
    logic                        rd_vld;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [PW-1:0]        prod;

    // activations are unsigned, so a zero sign bit keeps them positive in the signed multiply
    assign prod     = $signed(w_data) * $signed({1'b0, hid_data});
    assign busy     = (state == MAC) || (state == DRAIN) || (state == CMP);
    assign done     = state == DONE;
    assign w_addr   = (state == MAC) ? ADDR_WIDTH'(out_idx * NUM_HIDDEN + hid_idx) : '0;
    assign hid_addr = (state == MAC) ? hid_idx : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? MAC : IDLE;
            MAC:     state_nx = (hid_idx == HW'(NUM_HIDDEN-1)) ? DRAIN : MAC;
            DRAIN:   state_nx = CMP;
            CMP:     state_nx = (out_idx == 4'(NUM_OUT-1)) ? DONE : MAC;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            out_idx <= '0;
            hid_idx <= '0;
            rd_vld  <= 1'b0;
            acc     <= '0;
            digit   <= '0;
            max_acc <= '0;
        end else begin
            state  <= state_nx;
            rd_vld <= state == MAC;
            if (rd_vld)
                acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
            if (state == IDLE && start) begin
                out_idx <= '0;
                hid_idx <= '0;
                acc     <= '0;
            end
            if (state == MAC)
                hid_idx <= hid_idx + 1'b1;
            if (state == CMP) begin
                // strict compare keeps the lower index on ties
                if (out_idx == 4'd0 || acc > max_acc) begin
                    max_acc <= acc;
                    digit   <= out_idx;
                end
                if (out_idx != 4'(NUM_OUT-1)) begin
                    out_idx <= out_idx + 4'd1;
                    hid_idx <= '0;
                    acc     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_output_layer_mac.sv
// tb_output_layer_mac: randomized and directed runs checked against a plain-arithmetic arg-max model
module tb_output_layer_mac;
    logic        clk = 0, rst = 0, start = 0;
    logic [8:0]  w_addr;
    logic [7:0]  w_data = 0, hid_data = 0;
    logic [4:0]  hid_addr;
    logic        busy, done;
    logic [3:0]  digit;
    logic signed [23:0] max_acc;

    logic signed [7:0] rom [320];
    logic [7:0]        hid [32];
    int n_chk = 0, n_pass = 0;

    output_layer_mac dut (
        .clk(clk), .rst(rst), .start(start), .w_addr(w_addr), .w_data(w_data),
        .hid_addr(hid_addr), .hid_data(hid_data), .busy(busy), .done(done),
        .digit(digit), .max_acc(max_acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data   <= rom[w_addr];
        hid_data <= hid[hid_addr];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model(output int best_d, output int best_s);
        best_d = 0;
        best_s = 0;
        for (int o = 0; o < 10; o++) begin
            int s = 0;
            for (int h = 0; h < 32; h++) s += int'(rom[o*32+h]) * int'(hid[h]);
            if (o == 0 || s > best_s) begin
                best_d = o;
                best_s = s;
            end
        end
    endfunction

    // abort_at>0 resets the run mid-cycle at that cycle; otherwise extra starts probe the busy/done lockout
    task automatic run(input string tag, input int abort_at);
        int exp_d, exp_s, done_cyc, addr_err, got_d, got_s;
        model(exp_d, exp_s);
        done_cyc = 0; addr_err = 0; got_d = -1; got_s = 0;
        @(negedge clk); start = 1;
        @(posedge clk); #1; start = 0;
        for (int c = 1; c <= 400; c++) begin
            if (c <= 340 && abort_at == 0 && (c-1) % 34 < 32 &&
                (w_addr != 9'((c-1)/34*32 + (c-1)%34) || hid_addr != 5'((c-1)%34)))
                addr_err++;
            if (c == 1) chk({tag, "_busy_first"}, busy, 1);
            if (done && done_cyc == 0) begin
                done_cyc = c;
                got_d = digit;
                got_s = max_acc;
                chk({tag, "_busy_at_done"}, busy, 0);
            end
            if (abort_at == 0) start = (c == 50 || c == 200 || c == 341);
            if (c == 342 || c == 343) chk({tag, "_busy_after"}, busy, 0);
            if (c == abort_at) begin
                rst = 1; #1;
                chk({tag, "_rst_outs"}, {w_addr, hid_addr, busy, done, digit} , 0);
                chk({tag, "_rst_acc"}, max_acc, 0);
                #1 rst = 0;
            end
            @(posedge clk); #1;
        end
        start = 0;
        if (abort_at != 0) chk({tag, "_no_done"}, done_cyc, 0);
        else begin
            chk({tag, "_done_cycle"}, done_cyc, 341);
            chk({tag, "_digit"}, got_d, exp_d);
            chk({tag, "_max_acc"}, got_s, exp_s);
            chk({tag, "_addr_trace"}, addr_err, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 320; i++) rom[i] = 0;
        for (int i = 0; i < 32; i++) hid[i] = 0;
        rst = 1; #12;
        chk("reset_outs", {w_addr, hid_addr, busy, done, digit}, 0);
        chk("reset_acc", max_acc, 0);
        rst = 0;
        repeat (3) @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        for (int i = 0; i < 320; i++) rom[i] = (i/32 == 7) ? 8'sd1 : 8'sd0;
        for (int i = 0; i < 32; i++) hid[i] = 255;
        run("one_hot7", 0);
        chk("one_hot7_val", max_acc, 8160);
        for (int i = 0; i < 320; i++) rom[i] = 8'sd5;
        for (int i = 0; i < 32; i++) hid[i] = 10;
        run("tie", 0);
        chk("tie_digit", digit, 0);
        for (int i = 0; i < 320; i++) rom[i] = (i/32 == 3) ? -8'sd1 : -8'sd128;
        for (int i = 0; i < 32; i++) hid[i] = 255;
        run("neg", 0);
        chk("neg_val", max_acc, -8160);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 320; i++) rom[i] = 8'($urandom);
            for (int i = 0; i < 32; i++) hid[i] = 8'($urandom);
            run($sformatf("rand%0d", r), 0);
        end
        run("abort", 100);
        chk("abort_idle_busy", busy, 0);
        for (int i = 0; i < 320; i++) rom[i] = 8'($urandom_range(255));
        run("after_abort", 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
